// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and the iteration-counter width helper.
package seq_mul_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } state_t;

    // Width needed to index every bit of a w-bit multiplier (never below 1).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_mul_twos_abs.sv
// Combinational conditional two's-complement negate. Used both to take
// operand magnitudes at capture and to restore the product sign at the end.
// The most negative input negates to itself, which read as unsigned is the
// correct magnitude 2^(N-1).
module twos_abs #(
    parameter int N = 8
) (
    input  logic [N-1:0] value,
    input  logic         en,
    output logic [N-1:0] result
);

    logic signed [N-1:0] value_s;
    logic signed [N-1:0] negated_s;

    assign value_s   = value;
    assign negated_s = -value_s;
    assign result    = en ? negated_s : value;

endmodule

// File: rtl/seq_mul.sv
// Sequential W x W shift-add multiplier, unsigned or two's-complement signed
// per operation. MSB-first accumulation over W cycles plus one sign-fix
// cycle; the product is held in a register until the next result.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           ck,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sgn,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] O,
    output logic           busy,
    output logic           fin
);

    localparam int            CW   = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t          state;
    logic [W-1:0]    amag;
    logic [W-1:0]    bmag;
    logic            neg;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   cnt;

    logic [W-1:0]    a_abs;
    logic [W-1:0]    b_abs;
    logic            a_neg;
    logic            b_neg;
    logic            accept;
    logic [CW-1:0]   bit_idx;
    logic [2*W-1:0]  addend;
    logic [2*W-1:0]  acc_next;
    logic [2*W-1:0]  acc_fix;

    // Operand signs only matter in signed mode; unsigned operands pass through.
    assign a_neg = sgn & A[W-1];
    assign b_neg = sgn & B[W-1];

    // A new operation may be accepted from IDLE or straight out of DONE.
    assign accept = start && ((state == IDLE) || (state == DONE));

    twos_abs #(.N(W)) u_abs_a (
        .value  (A),
        .en     (a_neg),
        .result (a_abs)
    );

    twos_abs #(.N(W)) u_abs_b (
        .value  (B),
        .en     (b_neg),
        .result (b_abs)
    );

    twos_abs #(.N(2 * W)) u_fix (
        .value  (acc),
        .en     (neg),
        .result (acc_fix)
    );

    // One MSB-first shift-add step: the multiplier bit for iteration cnt is W-1-cnt.
    always_comb begin
        bit_idx  = LAST - cnt;
        addend   = bmag[bit_idx] ? {{W{1'b0}}, amag} : '0;
        acc_next = {acc[2*W-2:0], 1'b0} + addend;
    end

    // Control FSM with registered busy/fin/product outputs.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            amag  <= '0;
            bmag  <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            O     <= '0;
            busy  <= 1'b0;
            fin   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    fin <= 1'b0;
                    if (accept) begin
                        amag  <= a_abs;
                        bmag  <= b_abs;
                        neg   <= a_neg ^ b_neg;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    O     <= acc_fix;
                    busy  <= 1'b0;
                    fin   <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    fin   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Directed and randomized check of seq_mul at W=8, with W=4 and W=16
// instances for signed sweeps against a reference product.
`timescale 1ns/1ps
module tb_seq_mul;

    logic ck;
    logic rst_n;

    logic        start8, sgn8, busy8, fin8;
    logic [7:0]  a8, b8;
    logic [15:0] o8;

    logic        start4, sgn4, busy4, fin4;
    logic [3:0]  a4, b4;
    logic [7:0]  o4;

    logic        start16, sgn16, busy16, fin16;
    logic [15:0] a16, b16;
    logic [31:0] o16;

    int errors = 0;
    int checks = 0;

    seq_mul #(.W(8)) dut8 (
        .ck(ck), .rst_n(rst_n), .start(start8), .sgn(sgn8),
        .A(a8), .B(b8), .O(o8), .busy(busy8), .fin(fin8)
    );

    seq_mul #(.W(4)) dut4 (
        .ck(ck), .rst_n(rst_n), .start(start4), .sgn(sgn4),
        .A(a4), .B(b4), .O(o4), .busy(busy4), .fin(fin4)
    );

    seq_mul #(.W(16)) dut16 (
        .ck(ck), .rst_n(rst_n), .start(start16), .sgn(sgn16),
        .A(a16), .B(b16), .O(o16), .busy(busy16), .fin(fin16)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Launch one W=8 operation; returns edges from acceptance to fin and busy cycles seen.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output int lat, output int bcyc);
        @(negedge ck);
        a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
        @(posedge ck); #1;
        start8 = 1'b0;
        lat = 0;
        bcyc = busy8 ? 1 : 0;
        while (!fin8 && lat < 40) begin
            @(posedge ck); #1;
            lat++;
            if (busy8) bcyc++;
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, output int lat);
        @(negedge ck);
        a4 = a; b4 = b; sgn4 = 1'b1; start4 = 1'b1;
        @(posedge ck); #1;
        start4 = 1'b0;
        lat = 0;
        while (!fin4 && lat < 40) begin
            @(posedge ck); #1;
            lat++;
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge ck);
        a16 = a; b16 = b; sgn16 = 1'b1; start16 = 1'b1;
        @(posedge ck); #1;
        start16 = 1'b0;
        lat = 0;
        while (!fin16 && lat < 60) begin
            @(posedge ck); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bcyc, fcount;
        logic signed [3:0]  sa4, sb4;
        logic signed [15:0] sa16, sb16;
        longint p;
        logic [7:0]  e4;
        logic [31:0] e16;

        rst_n = 1'b0;
        start8 = 0; sgn8 = 0; a8 = '0; b8 = '0;
        start4 = 0; sgn4 = 0; a4 = '0; b4 = '0;
        start16 = 0; sgn16 = 0; a16 = '0; b16 = '0;
        repeat (3) @(posedge ck);
        #1;
        check("rst_O",    64'(o8),    64'h0);
        check("rst_busy", 64'(busy8), 64'h0);
        check("rst_fin",  64'(fin8),  64'h0);
        @(negedge ck);
        rst_n = 1'b1;

        // 1: unsigned 255*255, busy for 9 cycles, one-cycle fin, product held
        op8(8'd255, 8'd255, 1'b0, lat, bcyc);
        check("t1_lat",  64'(lat),  64'd9);
        check("t1_busy", 64'(bcyc), 64'd9);
        check("t1_O",    64'(o8),   64'hFE01);
        @(posedge ck); #1;
        check("t1_fin_drop", 64'(fin8), 64'h0);
        repeat (4) @(posedge ck);
        #1;
        check("t1_hold", 64'(o8), 64'hFE01);

        // 2: signed corner cases
        op8(8'h80, 8'h80, 1'b1, lat, bcyc);
        check("t2_minmin", 64'(o8), 64'h4000);
        op8(8'h80, 8'h01, 1'b1, lat, bcyc);
        check("t2_min_one", 64'(o8), 64'hFF80);
        op8(8'hFF, 8'h03, 1'b1, lat, bcyc);
        check("t2_m1_3", 64'(o8), 64'hFFFD);
        op8(8'hFB, 8'hFA, 1'b1, lat, bcyc);
        check("t2_m5_m6", 64'(o8), 64'h001E);
        op8(8'h80, 8'h80, 1'b0, lat, bcyc);
        check("t2_uns128", 64'(o8), 64'h4000);
        op8(8'hFF, 8'h03, 1'b0, lat, bcyc);
        check("t2_uns255_3", 64'(o8), 64'h02FD);

        // 3: zero operand keeps the full latency
        op8(8'd0, 8'd200, 1'b0, lat, bcyc);
        check("t3_O",   64'(o8), 64'h0);
        check("t3_lat", 64'(lat), 64'd9);

        // 4: start held high; junk operands during CALC/FIX must be ignored
        @(negedge ck);
        a8 = 8'd3; b8 = 8'd5; sgn8 = 1'b0; start8 = 1'b1;
        @(posedge ck); #1;
        a8 = 8'd200; b8 = 8'd200;
        lat = 0;
        while (!fin8 && lat < 40) begin
            @(posedge ck); #1;
            lat++;
        end
        check("t4_lat1", 64'(lat), 64'd9);
        check("t4_O1",   64'(o8),  64'd15);
        a8 = 8'd7; b8 = 8'd9;
        @(posedge ck); #1;
        check("t4_rebusy", 64'(busy8), 64'h1);
        check("t4_fin_low", 64'(fin8), 64'h0);
        a8 = 8'd250; b8 = 8'd250;
        lat = 1;
        while (!fin8 && lat < 40) begin
            @(posedge ck); #1;
            lat++;
        end
        check("t4_gap", 64'(lat), 64'd10);
        check("t4_O2",  64'(o8),  64'd63);
        start8 = 1'b0;
        @(posedge ck); #1;

        // 5: asynchronous reset during CALC aborts the operation
        @(negedge ck);
        a8 = 8'd100; b8 = 8'd100; sgn8 = 1'b0; start8 = 1'b1;
        @(posedge ck); #1;
        start8 = 1'b0;
        repeat (4) @(posedge ck);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_O",    64'(o8),    64'h0);
        check("t5_busy", 64'(busy8), 64'h0);
        check("t5_fin",  64'(fin8),  64'h0);
        @(negedge ck);
        rst_n = 1'b1;
        fcount = 0;
        repeat (15) begin
            @(posedge ck); #1;
            if (fin8) fcount++;
        end
        check("t5_nofin", 64'(fcount), 64'd0);
        op8(8'd12, 8'd12, 1'b0, lat, bcyc);
        check("t5_O_after", 64'(o8),  64'd144);
        check("t5_lat",     64'(lat), 64'd9);

        // 6: signed sweeps at W=4 and W=16 against a reference product
        op4(4'h8, 4'h8, lat);
        check("w4_minmin", 64'(o4), 64'h40);
        for (int i = 0; i < 1000; i++) begin
            sa4 = 4'($urandom);
            sb4 = 4'($urandom);
            p = longint'(sa4) * longint'(sb4);
            e4 = p[7:0];
            op4(sa4, sb4, lat);
            check("w4_O",   64'(o4),  64'(e4));
            check("w4_lat", 64'(lat), 64'd5);
        end
        op16(16'h8000, 16'h8000, lat);
        check("w16_minmin", 64'(o16), 64'h4000_0000);
        for (int i = 0; i < 1000; i++) begin
            sa16 = 16'($urandom);
            sb16 = 16'($urandom);
            p = longint'(sa16) * longint'(sb16);
            e16 = p[31:0];
            op16(sa16, sb16, lat);
            check("w16_O",   64'(o16), 64'(e16));
            check("w16_lat", 64'(lat), 64'd17);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
Parametrised sequential shift-add multiplier for W-bit operands, producing a 2W-bit product over W+1 clock cycles. Supports an unsigned mode and a two's-complement signed mode, selected per operation. The handshake is start/busy/fin, and the product is held until the next operation. It is the general-width successor of the team's fixed 8-bit multiplier and feeds datapath blocks that cannot afford a combinational W×W array.

Parameters:
W, 8, operand width in bits (legal range 2..32); product width is 2W.

Ports:
ck  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request a new operation; sampled only when busy=0.
sgn  in  1  1 = signed (two's complement) operands, 0 = unsigned; sampled with start.
A  in  W  multiplicand; sampled with start.
B  in  W  multiplier; sampled with start.
O  out  2W  product; valid and stable while fin=1 and until the next accepted start.
busy  out  1  high from the cycle after an accepted start until fin rises.
fin  out  1  one-cycle pulse; product valid.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; O=0, busy=0, fin=0.
  - Internal operand, accumulator and counter registers are cleared.
  - Reset mid-operation aborts the operation; no fin is produced.
- States: IDLE, CALC, FIX, DONE. Encoding is taken from the package.
- IDLE (busy=0, fin=0):
  - On an edge with start=1, capture A, B and sgn, then go to CALC.
  - In signed mode, capture |A| and |B| as W-bit unsigned magnitudes (the most negative value maps to 2^(W-1)). Record neg = A[W-1] XOR B[W-1].
  - In unsigned mode, capture A and B unchanged with neg=0.
  - Clear the accumulator and set the counter to 0.
- CALC (busy=1):
  - One iteration per edge, MSB-first: acc <= (acc<<1) + (Bmag[W-1-cnt] ? Amag : 0); cnt <= cnt+1.
  - The accumulator is 2W bits and never overflows (maximum (2^W-1)^2).
  - After W iterations (the edge where cnt=W-1), go to FIX.
  - start is ignored in CALC.
- FIX (busy=1):
  - One edge: O <= neg ? (~acc + 1) : acc, truncated to 2W bits. Go to DONE.
  - start is ignored in FIX.
- DONE (busy=0, fin=1 for exactly this cycle):
  - On the next edge, return to IDLE with fin=0.
  - If start=1 in DONE, it is accepted exactly as in IDLE: go directly to CALC. Back-to-back operations are allowed.
- Latency: if start is accepted at edge k, fin=1 and O are valid in the cycle after edge k+W+1. That gives W+1 cycles of busy.
- O changes only at the FIX edge and at reset. It holds through IDLE and through the next CALC.
- Zero operand: no early termination; latency is fixed at W+1.
- Signed edge case: (-2^(W-1)) × (-2^(W-1)) = 2^(2W-2). This is exact and representable in 2W bits.
- Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package seq_mul_pkg holds:
  - state encoding constants ST_IDLE=0, ST_CALC=1, ST_FIX=2, ST_DONE=3;
  - a function returning the counter width, clog2(W).
- One natural sub-module: twos_abs #(N), a combinational N-bit magnitude/negate helper (inputs value, en; output en ? -value : value).
  - Instantiated for the A and B magnitudes at capture.
  - Instantiated once at width 2W for the FIX correction.

Test Plan:
1. W=8, unsigned, A=255, B=255, single start pulse -> busy high 9 cycles, fin pulse one cycle, O=16'hFE01; O holds after fin drops.
2. W=8, signed, A=8'h80 (-128), B=8'h80 -> O=16'h4000. Then A=8'h80, B=8'h01 -> O=16'hFF80. Then A=8'hFF, B=8'h03 -> O=16'hFFFD.
3. W=8, unsigned, A=0, B=200 -> O=0 and fin exactly 9 cycles after the start edge (no early finish).
4. Start held high continuously, operand pairs (3,5) then (7,9) unsigned, with second operands presented in the DONE cycle -> fins 10 cycles apart, O=15 then O=63; start during CALC/FIX has no effect.
5. Reset asserted asynchronously (mid-cycle) at CALC iteration 4 -> O=0, busy=0, fin=0 immediately; no fin after release; next start (A=12, B=12) gives O=144.
6. Parameter sweep W=4 and W=16, signed random operands (≥1000 each) against a reference model -> every O matches; fin latency is exactly W+1.
